// File: rtl/parity_frame_accumulator_pkg.sv
// Shared types and helpers for the parity frame accumulator and later checker blocks.
// The state enum is exported so testbenches and checkers can observe the FSM directly.
package parity_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Number of bits needed to hold any value 0..max inclusive.
    function automatic int count_width(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/parity_frame_accumulator_if.sv
// Beat-in / result-out bundle for the parity frame accumulator.
// Handshake: a transfer happens on a rising clk edge where valid && ready are both high;
// the producer holds valid and payload steady until that edge, and ready never depends on valid.
interface parity_frame_accumulator_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             odd_mode;
    logic             check_en;
    logic             exp_parity;

    logic             out_valid;
    logic             out_ready;
    logic             out_parity;
    logic             out_error;
    logic [CW-1:0]    out_count;
    logic             out_overflow;

    modport master (
        output in_valid, in_data, in_last, odd_mode, check_en, exp_parity, out_ready,
        input  in_ready, out_valid, out_parity, out_error, out_count, out_overflow
    );

    modport slave (
        input  in_valid, in_data, in_last, odd_mode, check_en, exp_parity, out_ready,
        output in_ready, out_valid, out_parity, out_error, out_count, out_overflow
    );
endinterface

// File: rtl/parity_frame_accumulator_reduce.sv
// Combinational XOR reduction of one data word to a single parity bit.
// WIDTH=1 degenerates to a wire.
module parity_reduce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    output logic             parity_o
);
    assign parity_o = ^data_i;
endmodule

// File: rtl/parity_frame_accumulator.sv
// Streaming frame parity generator/checker: XORs every accepted beat, then holds
// parity, check result, beat count and overflow flag until the consumer takes them.
module parity_frame_accumulator
    import parity_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int MAX_WORDS = 16,
    localparam int CW        = count_width(MAX_WORDS)
) (
    input  logic                          clk,
    input  logic                          rst,
    parity_frame_accumulator_if.slave     bus,
    output state_e                        state_o
);

    state_e        state_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          out_parity_q;
    logic          out_error_q;
    logic [CW-1:0] out_count_q;
    logic          out_overflow_q;

    logic          acc_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic          mode_q;
    logic          mid_frame_q;

    logic          beat_par;
    logic          beat_fire;
    logic          acc_d;
    logic [CW-1:0] cnt_d;
    logic          ovf_d;
    logic          mode_d;
    logic          parity_d;

    parity_reduce #(.WIDTH(WIDTH)) u_reduce (
        .data_i   (bus.in_data),
        .parity_o (beat_par)
    );

    // Mode comes from the live input only on the first beat; later beats reuse the latched copy.
    always_comb begin
        beat_fire = bus.in_valid && in_ready_q;
        acc_d     = acc_q ^ beat_par;
        mode_d    = mid_frame_q ? mode_q : bus.odd_mode;
        cnt_d     = (cnt_q == CW'(MAX_WORDS)) ? cnt_q : cnt_q + CW'(1);
        ovf_d     = ovf_q || (cnt_q == CW'(MAX_WORDS));
        parity_d  = acc_d ^ mode_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ACCUM;
            in_ready_q     <= 1'b1;
            out_valid_q    <= 1'b0;
            out_parity_q   <= 1'b0;
            out_error_q    <= 1'b0;
            out_count_q    <= '0;
            out_overflow_q <= 1'b0;
            acc_q          <= 1'b0;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            mode_q         <= 1'b0;
            mid_frame_q    <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (beat_fire) begin
                        if (bus.in_last) begin
                            out_parity_q   <= parity_d;
                            out_error_q    <= bus.check_en && (parity_d != bus.exp_parity);
                            out_count_q    <= cnt_d;
                            out_overflow_q <= ovf_d;
                            acc_q          <= 1'b0;
                            cnt_q          <= '0;
                            ovf_q          <= 1'b0;
                            mode_q         <= 1'b0;
                            mid_frame_q    <= 1'b0;
                            state_q        <= HOLD;
                            in_ready_q     <= 1'b0;
                            out_valid_q    <= 1'b1;
                        end else begin
                            acc_q       <= acc_d;
                            cnt_q       <= cnt_d;
                            ovf_q       <= ovf_d;
                            mode_q      <= mode_d;
                            mid_frame_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_q     <= ACCUM;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ACCUM;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_parity   = out_parity_q;
    assign bus.out_error    = out_error_q;
    assign bus.out_count    = out_count_q;
    assign bus.out_overflow = out_overflow_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_parity_frame_accumulator.sv
// Directed bench for parity_frame_accumulator (WIDTH=8, MAX_WORDS=16) with hand-computed results.
module tb_parity_frame_accumulator;
    import parity_pkg::*;

    localparam int WIDTH     = 8;
    localparam int MAX_WORDS = 16;
    localparam int CW        = 5;

    logic   clk;
    logic   rst;
    state_e state;
    int     total;
    int     bad;

    parity_frame_accumulator_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

    parity_frame_accumulator #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drives one beat and returns just after the edge that transferred it.
    task automatic send_beat(input logic [WIDTH-1:0] d, input logic last, input logic mode,
                             input logic chk, input logic expp);
        int n;
        bus.in_valid   = 1'b1;
        bus.in_data    = d;
        bus.in_last    = last;
        bus.odd_mode   = mode;
        bus.check_en   = chk;
        bus.exp_parity = expp;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL send_beat_timeout: in_ready=%b required 1 within 20 cycles", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.out_parity, bus.out_error, bus.out_count, bus.out_overflow}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs: rdy/vld/par/err/cnt/ovf=%b/%b/%b/%b/%0d/%b required 1/0/0/0/0/0",
                     bus.in_ready, bus.out_valid, bus.out_parity, bus.out_error, bus.out_count, bus.out_overflow);
        end
        total++;
        if (state !== ACCUM) begin
            bad++;
            $display("FAIL reset_state: state=%0d required %0d", state, ACCUM);
        end
    endtask

    task automatic test_even_frame();
        send_beat(8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        send_beat(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if ({bus.out_valid, bus.out_parity, bus.out_error, bus.out_count, bus.out_overflow}
            !== {1'b1, 1'b1, 1'b0, 5'd2, 1'b0}) begin
            bad++;
            $display("FAIL even_frame: vld/par/err/cnt/ovf=%b/%b/%b/%0d/%b required 1/1/0/2/0",
                     bus.out_valid, bus.out_parity, bus.out_error, bus.out_count, bus.out_overflow);
        end
        total++;
        if ({bus.in_ready, state} !== {1'b0, HOLD}) begin
            bad++;
            $display("FAIL even_hold: in_ready=%b state=%0d required 0 %0d", bus.in_ready, state, HOLD);
        end
        take_result();
        total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL even_release: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_odd_single();
        send_beat(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if ({bus.out_valid, bus.out_parity, bus.out_error, bus.out_count, bus.out_overflow}
            !== {1'b1, 1'b1, 1'b0, 5'd1, 1'b0}) begin
            bad++;
            $display("FAIL odd_single: vld/par/err/cnt/ovf=%b/%b/%b/%0d/%b required 1/1/0/1/0",
                     bus.out_valid, bus.out_parity, bus.out_error, bus.out_count, bus.out_overflow);
        end
        take_result();
    endtask

    task automatic test_check();
        send_beat(8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
        total++;
        if ({bus.out_valid, bus.out_parity, bus.out_error} !== 3'b101) begin
            bad++;
            $display("FAIL check_mismatch: vld/par/err=%b/%b/%b required 1/0/1",
                     bus.out_valid, bus.out_parity, bus.out_error);
        end
        take_result();
        send_beat(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
        total++;
        if ({bus.out_valid, bus.out_parity, bus.out_error} !== 3'b100) begin
            bad++;
            $display("FAIL check_match: vld/par/err=%b/%b/%b required 1/0/0",
                     bus.out_valid, bus.out_parity, bus.out_error);
        end
        take_result();
        // Parity 1 against expected 0, but checking disabled: no error.
        send_beat(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if ({bus.out_parity, bus.out_error} !== 2'b10) begin
            bad++;
            $display("FAIL check_disabled: par/err=%b/%b required 1/0", bus.out_parity, bus.out_error);
        end
        take_result();
    endtask

    task automatic test_mode_latch();
        // First beat odd, later beats even: odd must stick. Data XOR = 0, so parity = 1.
        send_beat(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        send_beat(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        send_beat(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if ({bus.out_parity, bus.out_count} !== {1'b1, 5'd3}) begin
            bad++;
            $display("FAIL mode_latch: par/cnt=%b/%0d required 1/3", bus.out_parity, bus.out_count);
        end
        take_result();
    endtask

    task automatic test_boundary_count();
        // Exactly MAX_WORDS beats: saturated count but no overflow. 16 ones, even -> 0.
        for (int i = 0; i < MAX_WORDS; i++) send_beat(8'h01, (i == MAX_WORDS - 1), 1'b0, 1'b0, 1'b0);
        total++;
        if ({bus.out_parity, bus.out_count, bus.out_overflow} !== {1'b0, 5'd16, 1'b0}) begin
            bad++;
            $display("FAIL count_exact: par/cnt/ovf=%b/%0d/%b required 0/16/0",
                     bus.out_parity, bus.out_count, bus.out_overflow);
        end
        take_result();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 18; i++) send_beat(8'h01, (i == 17), 1'b0, 1'b0, 1'b0);
        total++;
        if ({bus.out_valid, bus.out_parity, bus.out_count, bus.out_overflow} !== {1'b1, 1'b0, 5'd16, 1'b1}) begin
            bad++;
            $display("FAIL overflow: vld/par/cnt/ovf=%b/%b/%0d/%b required 1/0/16/1",
                     bus.out_valid, bus.out_parity, bus.out_count, bus.out_overflow);
        end
        take_result();
        // Overflow state must not leak into the next frame.
        send_beat(8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if ({bus.out_parity, bus.out_count, bus.out_overflow} !== {1'b1, 5'd1, 1'b0}) begin
            bad++;
            $display("FAIL after_overflow: par/cnt/ovf=%b/%0d/%b required 1/1/0",
                     bus.out_parity, bus.out_count, bus.out_overflow);
        end
        take_result();
    endtask

    task automatic test_backpressure_reset();
        int stable_bad;
        send_beat(8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        send_beat(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        // A beat offered during HOLD must be ignored.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h01;
        bus.in_last  = 1'b1;
        stable_bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if ({bus.in_ready, bus.out_valid, bus.out_parity, bus.out_error, bus.out_count, bus.out_overflow}
                !== {1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 1'b0}) stable_bad++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        total++;
        if (stable_bad !== 0) begin
            bad++;
            $display("FAIL backpressure_stable: unstable_cycles=%0d required 0", stable_bad);
        end
        take_result();
        total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b required 0 1",
                     bus.out_valid, bus.in_ready);
        end
        for (int i = 0; i < 3; i++) send_beat(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({bus.in_ready, bus.out_valid, state} !== {1'b1, 1'b0, ACCUM}) begin
            bad++;
            $display("FAIL midframe_reset: in_ready=%b out_valid=%b state=%0d required 1 0 %0d",
                     bus.in_ready, bus.out_valid, state, ACCUM);
        end
        send_beat(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if ({bus.out_valid, bus.out_parity, bus.out_count, bus.out_overflow} !== {1'b1, 1'b1, 5'd1, 1'b0}) begin
            bad++;
            $display("FAIL post_reset_frame: vld/par/cnt/ovf=%b/%b/%0d/%b required 1/1/1/0",
                     bus.out_valid, bus.out_parity, bus.out_count, bus.out_overflow);
        end
        take_result();
    endtask

    task automatic test_back_to_back();
        // Result taken the cycle after last; next frame starts immediately.
        send_beat(8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send_beat(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        send_beat(8'h10, 1'b1, 1'b0, 1'b1, 1'b1);
        total++;
        if ({bus.out_parity, bus.out_error, bus.out_count} !== {1'b1, 1'b0, 5'd2}) begin
            bad++;
            $display("FAIL back_to_back: par/err/cnt=%b/%b/%0d required 1/0/2",
                     bus.out_parity, bus.out_error, bus.out_count);
        end
        take_result();
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_last    = 1'b0;
        bus.odd_mode   = 1'b0;
        bus.check_en   = 1'b0;
        bus.exp_parity = 1'b0;
        bus.out_ready  = 1'b0;
        test_reset();
        test_even_frame();
        test_odd_single();
        test_check();
        test_mode_latch();
        test_boundary_count();
        test_overflow();
        test_backpressure_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parity_frame_accumulator.md
Name: parity_frame_accumulator

Overview:
- Streaming parity generator/checker, successor to the 3-input combinational parity cell.
- Accepts a frame of WIDTH-bit words over a valid/ready handshake and accumulates XOR across all beats.
- On the last beat it presents the frame parity (even or odd mode), an optional check result against an expected bit, and the beat count.
- Sits between a lab data source (switches/UART byte stream) and status LEDs/display logic.

Parameters:
- WIDTH, 8, data bits per beat (>=1).
- MAX_WORDS, 16, beats counted per frame before saturation (>=1).
- CW, $clog2(MAX_WORDS+1), width of out_count (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  source has a beat.
- in_ready  output  1  block accepts a beat; beat transfers when in_valid && in_ready.
- in_data  input  WIDTH  beat payload.
- in_last  input  1  marks final beat of the frame.
- odd_mode  input  1  0 = even parity (total ones including P is even), 1 = odd parity; sampled on first beat of a frame.
- check_en  input  1  compare against exp_parity; sampled with the last beat.
- exp_parity  input  1  expected parity bit; sampled with the last beat.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result; result transfers when out_valid && out_ready.
- out_parity  output  1  computed frame parity bit.
- out_error  output  1  check_en && (out_parity != exp_parity); 0 when check disabled.
- out_count  output  CW  beats in the frame, saturating at MAX_WORDS.
- out_overflow  output  1  frame had more than MAX_WORDS beats.

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: state=ACCUM, in_ready=1, out_valid=0, out_parity=0, out_error=0, out_count=0, out_overflow=0. Internal accumulator, count, mode and first-beat flag are cleared.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1. Outputs are stable until out_ready.
- ACCUM, non-last beat accepted:
  - acc <= acc ^ (^in_data).
  - cnt <= cnt+1, saturating at MAX_WORDS; ovf <= 1 if cnt==MAX_WORDS already.
  - On the first beat of a frame, latch odd_mode.
- ACCUM, last beat accepted:
  - Next cycle enter HOLD with out_parity = acc ^ (^in_data) ^ mode.
  - out_count and out_overflow include this beat.
  - out_error uses check_en/exp_parity sampled on this beat.
  - Internal acc, cnt, ovf and first-beat flag are cleared. Latency from last beat to out_valid is 1 cycle.
- A single-beat frame (in_last on the first beat) is legal. Mode is sampled on that same beat.
- HOLD: when out_ready=1, return to ACCUM next cycle and drop out_valid. out_* hold their last values; they are not meaningful while out_valid=0.
- No overlap: in_ready=0 in HOLD, so the minimum frame-to-frame spacing is 2 cycles (last beat, then 1 result cycle with out_ready high).
- in_valid=0 in ACCUM: no state change. Idle gaps between beats are allowed.
- odd_mode changes mid-frame are ignored. The value latched on the first beat is used.
- rst mid-frame or in HOLD: the partial frame or pending result is discarded and all reset values apply next cycle.
- WIDTH=1 is legal: the per-beat reduction is the bit itself.

Decomposition:
- Shared package parity_pkg:
  - state enum {ACCUM, HOLD}.
  - Function count_width(max) returning $clog2(max+1).
- One sub-module is natural: parity_reduce, parameter WIDTH. It is a combinational XOR reduction of in_data to 1 bit, reused by later checker blocks.

Test Plan:
- Reset, then idle -> in_ready=1, out_valid=0, all out_* = 0.
- Even mode, WIDTH=8, frame 8'h03, 8'h01 (last), out_ready=1 -> 1 cycle after last: out_valid=1, out_parity=1, out_count=2, out_error=0, out_overflow=0.
- Odd mode, single-beat frame 8'h00, last=1 -> out_parity=1, out_count=1.
- Check: even mode, frame 8'hFF (last), check_en=1, exp_parity=1 -> out_parity=0, out_error=1. Repeat with exp_parity=0 -> out_error=0.
- Overflow, MAX_WORDS=16: 18 beats of 8'h01, even mode -> out_count=16, out_overflow=1, out_parity=0.
- Backpressure/reset: hold out_ready=0 for 5 cycles -> in_ready=0 and outputs stable. Then assert rst mid-next-frame after 3 beats -> next cycle in_ready=1, out_valid=0. The following frame 8'h01 (last) gives out_count=1, out_parity=1 with no residue from the aborted frame.
